// File: rtl/ram_quad_bank.sv
// Four independent single-port synchronous RAM banks sharing clk/rst_n.
// Each bank writes through to its registered read port; memory arrays are never reset.

module ram_quad_bank_bank #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_write,
    input  logic                     wr_signal,
    output logic [DATA_WIDTH-1:0]    data_read
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on the array so it maps onto RAM; writes are gated off while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_signal) begin
            mem[address] <= data_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_read <= '0;
        end else if (wr_signal) begin
            data_read <= data_write;
        end else begin
            data_read <= mem[address];
        end
    end
endmodule

module ram_quad_bank #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDRESS_WIDTH_1 = 10,
    parameter int ADDRESS_WIDTH_2 = 12,
    parameter int ADDRESS_WIDTH_3 = 12,
    parameter int ADDRESS_WIDTH_4 = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDRESS_WIDTH_1-1:0] address_1,
    input  logic [ADDRESS_WIDTH_2-1:0] address_2,
    input  logic [ADDRESS_WIDTH_3-1:0] address_3,
    input  logic [ADDRESS_WIDTH_4-1:0] address_4,
    input  logic [DATA_WIDTH-1:0]      data_write_1,
    input  logic [DATA_WIDTH-1:0]      data_write_2,
    input  logic [DATA_WIDTH-1:0]      data_write_3,
    input  logic [DATA_WIDTH-1:0]      data_write_4,
    input  logic                       WR_signal_1,
    input  logic                       WR_signal_2,
    input  logic                       WR_signal_3,
    input  logic                       WR_signal_4,
    output logic [DATA_WIDTH-1:0]      data_read_1,
    output logic [DATA_WIDTH-1:0]      data_read_2,
    output logic [DATA_WIDTH-1:0]      data_read_3,
    output logic [DATA_WIDTH-1:0]      data_read_4
);
    ram_quad_bank_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH_1)) u_bank_1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address_1),
        .data_write (data_write_1),
        .wr_signal  (WR_signal_1),
        .data_read  (data_read_1)
    );

    ram_quad_bank_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH_2)) u_bank_2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address_2),
        .data_write (data_write_2),
        .wr_signal  (WR_signal_2),
        .data_read  (data_read_2)
    );

    ram_quad_bank_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH_3)) u_bank_3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address_3),
        .data_write (data_write_3),
        .wr_signal  (WR_signal_3),
        .data_read  (data_read_3)
    );

    ram_quad_bank_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH_4)) u_bank_4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address_4),
        .data_write (data_write_4),
        .wr_signal  (WR_signal_4),
        .data_read  (data_read_4)
    );
endmodule

// File: tb/tb_ram_quad_bank.sv
// Directed bench for ram_quad_bank: a memory model feeds a scoreboard queue of
// expected read-port values that are popped and checked after each clock edge.

module tb_ram_quad_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  address_1 = '0;
    logic [11:0] address_2 = '0;
    logic [11:0] address_3 = '0;
    logic [6:0]  address_4 = '0;
    logic [63:0] data_write_1 = '0, data_write_2 = '0, data_write_3 = '0, data_write_4 = '0;
    logic        WR_signal_1 = 1'b0, WR_signal_2 = 1'b0, WR_signal_3 = 1'b0, WR_signal_4 = 1'b0;
    logic [63:0] data_read_1, data_read_2, data_read_3, data_read_4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          bank;
        bit          chk;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model[int];

    ram_quad_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address_1    (address_1),
        .address_2    (address_2),
        .address_3    (address_3),
        .address_4    (address_4),
        .data_write_1 (data_write_1),
        .data_write_2 (data_write_2),
        .data_write_3 (data_write_3),
        .data_write_4 (data_write_4),
        .WR_signal_1  (WR_signal_1),
        .WR_signal_2  (WR_signal_2),
        .WR_signal_3  (WR_signal_3),
        .WR_signal_4  (WR_signal_4),
        .data_read_1  (data_read_1),
        .data_read_2  (data_read_2),
        .data_read_3  (data_read_3),
        .data_read_4  (data_read_4)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rd_of(int b);
        case (b)
            0:       return data_read_1;
            1:       return data_read_2;
            2:       return data_read_3;
            default: return data_read_4;
        endcase
    endfunction

    function automatic int addr_of(int b);
        case (b)
            0:       return int'(address_1);
            1:       return int'(address_2);
            2:       return int'(address_3);
            default: return int'(address_4);
        endcase
    endfunction

    function automatic bit wr_of(int b);
        case (b)
            0:       return WR_signal_1;
            1:       return WR_signal_2;
            2:       return WR_signal_3;
            default: return WR_signal_4;
        endcase
    endfunction

    function automatic logic [63:0] wdata_of(int b);
        case (b)
            0:       return data_write_1;
            1:       return data_write_2;
            2:       return data_write_3;
            default: return data_write_4;
        endcase
    endfunction

    task automatic set_op(int b, bit wr, int addr, logic [63:0] d);
        case (b)
            0: begin WR_signal_1 = wr; address_1 = addr[9:0];  data_write_1 = d; end
            1: begin WR_signal_2 = wr; address_2 = addr[11:0]; data_write_2 = d; end
            2: begin WR_signal_3 = wr; address_3 = addr[11:0]; data_write_3 = d; end
            default: begin WR_signal_4 = wr; address_4 = addr[6:0]; data_write_4 = d; end
        endcase
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expected read-port values for this edge, clock, then pop and compare.
    task automatic step(string tag);
        exp_t e;
        for (int b = 0; b < 4; b++) begin
            int key;
            key = b * 65536 + addr_of(b);
            e.bank = b;
            if (wr_of(b)) begin
                model[key] = wdata_of(b);
                e.chk = 1'b1;
                e.val = wdata_of(b);
            end else if (model.exists(key)) begin
                e.chk = 1'b1;
                e.val = model[key];
            end else begin
                e.chk = 1'b0;
                e.val = '0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) check($sformatf("%s_b%0d", tag, e.bank + 1), rd_of(e.bank), e.val);
        end
        for (int b = 0; b < 4; b++) set_op(b, 1'b0, addr_of(b), '0);
    endtask

    initial begin
        int maxa[4];
        maxa[0] = 1023; maxa[1] = 4095; maxa[2] = 4095; maxa[3] = 127;

        #2;
        for (int b = 0; b < 4; b++) check($sformatf("reset_init_b%0d", b + 1), rd_of(b), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        set_op(0, 1'b1, 1, 64'h1110a716aa948111);
        set_op(1, 1'b1, 2, 64'h2220a716aa9485d9);
        set_op(2, 1'b1, 3, 64'h3330a716aa9485d9);
        set_op(3, 1'b1, 4, 64'h4440a716aa9485d9);
        step("basic_wr");
        step("basic_rd");

        set_op(0, 1'b1, 1, 64'h9990a716aa948111);
        set_op(1, 1'b1, 2, 64'h8880a716aa9485d9);
        set_op(2, 1'b1, 3, 64'h7770a716aa9485d9);
        set_op(3, 1'b1, 4, 64'h6660a716aa9485d9);
        step("over_wr");
        step("over_rd");

        set_op(0, 1'b1, 1, 64'h5550a716aa948111);
        set_op(1, 1'b0, 2, '0);
        set_op(2, 1'b1, 3, 64'h1230a716aa9485d9);
        set_op(3, 1'b0, 4, '0);
        step("mixed");
        step("mixed_rd");

        set_op(1, 1'b1, 'hFFF, 64'hDEADBEEF00000001);
        step("wthru");
        step("wthru_rd");

        // Back-to-back writes to one address: the last one must win.
        set_op(3, 1'b1, 9, 64'h0000000000000111);
        step("b2b_a");
        set_op(3, 1'b1, 9, 64'h0000000000000222);
        step("b2b_b");
        step("b2b_rd");

        for (int b = 0; b < 4; b++) set_op(b, 1'b1, 0, {8'hA0 + 8'(b), 56'h00_1111_2222_3333});
        step("bnd_min_wr");
        for (int b = 0; b < 4; b++) set_op(b, 1'b1, maxa[b], {8'hB0 + 8'(b), 56'h00_4444_5555_6666});
        step("bnd_max_wr");
        for (int b = 0; b < 4; b++) set_op(b, 1'b0, 0, '0);
        step("bnd_min_rd");
        for (int b = 0; b < 4; b++) set_op(b, 1'b0, maxa[b], '0);
        step("bnd_max_rd");

        // Asynchronous reset mid-cycle; writes during reset must not land.
        #2;
        rst_n = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) check($sformatf("reset_async_b%0d", b + 1), rd_of(b), 64'h0);
        for (int b = 0; b < 4; b++) set_op(b, 1'b1, b + 1, 64'hBAD0BAD0BAD0BAD0);
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) check($sformatf("reset_hold_b%0d", b + 1), rd_of(b), 64'h0);
        for (int b = 0; b < 4; b++) set_op(b, 1'b0, b + 1, '0);
        rst_n = 1'b1;
        step("post_reset_rd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_quad_bank.md
Name: ram_quad_bank

Overview:
- Four independent single-port synchronous RAM banks in one block, sharing one clock and one reset.
- Each bank has its own address, write data, write enable and read data.
- Used as the ODE solver's data storage: bank 1 holds 1K words, banks 2 and 3 hold 4K words each, bank 4 holds 128 words; all words are 64-bit.
- The banks never interact; each can read or write in any cycle regardless of the others.

Parameters:
- DATA_WIDTH, 64, word width of all banks
- ADDRESS_WIDTH_1, 10, bank 1 address width (depth 2^10 = 1024)
- ADDRESS_WIDTH_2, 12, bank 2 address width (depth 4096)
- ADDRESS_WIDTH_3, 12, bank 3 address width (depth 4096)
- ADDRESS_WIDTH_4, 7, bank 4 address width (depth 128)

Ports:
- clk  in  1  single clock; all activity on rising edge
- rst_n  in  1  asynchronous, active-low reset
- address_1  in  ADDRESS_WIDTH_1  bank 1 word address
- address_2  in  ADDRESS_WIDTH_2  bank 2 word address
- address_3  in  ADDRESS_WIDTH_3  bank 3 word address
- address_4  in  ADDRESS_WIDTH_4  bank 4 word address
- data_write_1..4  in  DATA_WIDTH each  write data for bank n
- WR_signal_1..4  in  1 each  bank n write enable: 1 = write, 0 = read
- data_read_1..4  out  DATA_WIDTH each  registered read data of bank n

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset, when rst_n falls (no clock needed):
  - data_read_1..4 go to 0 immediately and stay 0 while rst_n = 0.
  - Memory contents are not cleared.
  - Writes are ignored while rst_n = 0.
- Reset release: normal operation resumes from the first rising clk edge after rst_n returns high.
- Each bank n on every rising clk edge with rst_n = 1:
  - WR_signal_n = 1: mem_n[address_n] <= data_write_n. In the same edge data_read_n <= data_write_n (write-first / write-through).
  - WR_signal_n = 0: data_read_n <= mem_n[address_n]; memory unchanged.
- Latency:
  - Read data is valid one rising edge after address is presented with WR low.
  - A value written at edge k can be read back at the edge k+1 read; no stall, no hazard.
- Back-to-back writes to the same address: the last write wins, and the next read returns it.
- Independence:
  - Any mix of reads and writes across the four banks in the same cycle is legal.
  - An operation on one bank never affects another bank's contents or output.
- Address range: every address value is in range; depth is exactly 2^ADDRESS_WIDTH_n, so there is no wrap or out-of-range case.
- Power-up contents are undefined. Reads of never-written locations return unspecified data; verification must not check them.
- No handshake: the enable is sampled only at the rising edge, and inputs must be stable around it.
- Storage must infer as block/distributed RAM: no reset on the memory arrays, one write port and one read port per bank.

Test Plan:
1. Reset: assert rst_n = 0 mid-operation after writes -> all data_read_n = 0 immediately, without a clock edge. Release, then read a previously written address -> the old contents are returned (memory preserved).
2. Basic write/read:
   - Addresses 1, 2, 3, 4 on banks 1–4.
   - Write 64'h1110a716aa948111, 64'h2220a716aa9485d9, 64'h3330a716aa9485d9, 64'h4440a716aa9485d9 with all WR = 1 for one edge.
   - Set WR = 0 and clock once -> each data_read_n equals its written value.
3. Overwrite: same addresses, write 64'h9990a716aa948111, 64'h8880a716aa9485d9, 64'h7770a716aa9485d9, 64'h6660a716aa9485d9 -> the next read returns the new values.
4. Mixed cycle:
   - WR_signal_1 = WR_signal_3 = 1 writing 64'h5550a716aa948111 and 64'h1230a716aa9485d9.
   - WR_signal_2 = WR_signal_4 = 0.
   - -> At that edge, banks 2 and 4 output 64'h8880a716aa9485d9 and 64'h6660a716aa9485d9.
   - After the following read edge, banks 1 and 3 output 64'h5550a716aa948111 and 64'h1230a716aa9485d9.
5. Write-through: write 64'hDEADBEEF00000001 to bank 2 address 12'hFFF -> data_read_2 shows it on the same edge. Read of address 12'hFFF on the next edge returns the same value.
6. Boundary/isolation:
   - Write distinct values to the max and min address of each bank (bank 1: 0 and 10'h3FF; bank 2: 0 and 12'hFFF; bank 3: 0 and 12'hFFF; bank 4: 0 and 7'h7F).
   - Read all back -> each returns its own value with no aliasing between addresses or banks.
